addfloat_issue_ctrl: RTL and testbench
======================================

Name:
addfloat_issue_ctrl

Overview:
- Request-side front end for the multi-cycle floating-point adder `addfloat`.
- Accepts tagged add/sub requests on a valid/ready stream and buffers them in a small FIFO.
- Issues one request at a time to the adder with a single-cycle `start`, holding the operands stable, and waits for `done`.
- Captures result and flags into a one-entry output buffer presented on a valid/ready stream.

Parameters:
- FLOAT_WIDTH, 64, operand/result width (32 or 64); passed through to the adder.
- FIFO_DEPTH, 4, request FIFO entries (power of 2, ≥2).
- TAG_WIDTH, 4, opaque request tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at posedge
- in_op1  in  FLOAT_WIDTH  first operand
- in_op2  in  FLOAT_WIDTH  second operand
- in_sub  in  1  1 = op1-op2, 0 = op1+op2
- in_tag  in  TAG_WIDTH  request tag
- fa_start  out  1  start pulse to adder
- fa_op1  out  FLOAT_WIDTH  adder operand 1
- fa_op2  out  FLOAT_WIDTH  adder operand 2
- fa_op_sub  out  1  adder op_sub
- fa_result  in  FLOAT_WIDTH  adder result
- fa_nan  in  1  adder nan_flag
- fa_ovf  in  1  adder overflow_flag
- fa_unf  in  1  adder underflow_flag
- fa_zero  in  1  adder zero_flag
- fa_done  in  1  adder done (level; stays high after completion)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready at posedge
- out_result  out  FLOAT_WIDTH  result
- out_flags  out  4  {nan, ovf, unf, zero}
- out_tag  out  TAG_WIDTH  tag of the request that produced the result
- busy  out  1  high when the FIFO is non-empty, an op is in flight, or out_valid is high

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - During reset: FIFO empty, state IDLE, fa_start=0, fa_op1/fa_op2/fa_op_sub=0, out_valid=0, out_result/out_flags/out_tag=0, busy=0.
  - in_ready=1 after release.
- FIFO:
  - in_ready = !full.
  - Push and pop may occur in the same cycle at any occupancy (never a push while full).
  - Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH-aware, with full/empty derived from the count.
- Operand register {op1, op2, sub, tag}:
  - Loaded on pop.
  - Drives fa_op1/fa_op2/fa_op_sub continuously.
  - Must not change from ISSUE through the capture cycle, because the adder reads the operands combinationally in late stages.
- FSM:
  - IDLE: if FIFO non-empty, pop into the operand register → ISSUE.
  - ISSUE: fa_start=1 for exactly one cycle → WAIT.
  - WAIT: fa_done is ignored in the first 2 WAIT cycles (guard counter; done can be stale high from the previous op, or high only for the adder's pipeline fill).
    - After the guard, if fa_done=1 and the output slot is free (out_valid=0, or out_ready=1 this cycle): capture fa_result, flags and tag; set out_valid.
    - Then, if FIFO non-empty, pop → ISSUE; else → IDLE.
    - If fa_done=1 but the slot is occupied: stay in WAIT. The adder holds its result because no new start is issued.
- Output: out_valid clears on out_ready unless a capture occurs in the same cycle; a capture in that cycle keeps out_valid=1 with new data.
- Latency (empty FIFO, out_ready=1): accept at edge E0 → pop E1 → start sampled E2 → fa_done high after E8 → out_valid high after E9. Out_valid therefore rises 9 edges after acceptance.
- Throughput: one op per 8 cycles when continuously fed.
- Capacity: FIFO_DEPTH queued + 1 in flight + 1 in the output buffer.
- Result ordering equals acceptance order.
- fa_start is never asserted while in WAIT.
- Reset mid-operation: in-flight op, queued requests and buffered result are discarded; the adder is reset by the same rst_n. The first post-reset request behaves as in the latency rule above.

Decomposition:
- Shared package `addfloat_pkg`:
  - FLOAT_WIDTH-derived constants (EXP_WIDTH, FRACTION_WIDTH, NAN/INF values).
  - out_flags bit indices (NAN=3, OVF=2, UNF=1, ZERO=0).
  - FSM state encoding.
  - ADDFLOAT_DONE_LATENCY = 6.
- One sub-module `addfloat_req_fifo`: synchronous FIFO of width 2*FLOAT_WIDTH+1+TAG_WIDTH with push/pop/full/empty/count.

Test Plan:
- 64-bit single op: 3FF0000000000000 + 4000000000000000, tag 5, out_ready=1 → exactly one fa_start pulse; out_valid rises 9 edges after accept; out_result=4008000000000000, out_flags=0000, out_tag=5.
- Back-to-back: 6 requests with in_valid held, out_ready=1:
  - in_ready drops once FIFO_DEPTH are queued with one in flight.
  - Results appear 8 cycles apart, in order, with tags 0..5.
- Subtract: 4008000000000000 - 3FF0000000000000 (in_sub=1) → 4000000000000000. Equal operands with in_sub=1 → out_flags=0001, result sign bit clear.
- NaN: in_op1=7FF8000000000000, in_op2=3FF0000000000000 → out_result=FFF8000000000000, out_flags=1000.
- Backpressure: out_ready=0 with 2 requests queued:
  - First result is held.
  - Second op completes and waits in WAIT with no further fa_start.
  - fa_op1/fa_op2 stay stable.
  - Raising out_ready drains both results in order on consecutive handshakes.
- Reset mid-op: assert rst_n=0 4 cycles after fa_start.
  - All outputs go to 0 immediately; no stale result appears after release.
  - A new request then completes with 9-edge latency.

Source files
------------

// File: rtl/addfloat_pkg.sv
// Shared definitions for the addfloat request front end: format helpers,
// result flag bit positions, issue FSM encoding and adder timing constants.
package addfloat_pkg;

    localparam int ADDFLOAT_DONE_LATENCY = 6;
    // fa_done may still be high from the previous op for this many WAIT cycles
    localparam int WAIT_GUARD_CYCLES     = 2;

    localparam int FLAG_NAN  = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issue_state_t;

    function automatic int exp_width(input int float_width);
        return (float_width == 32) ? 8 : 11;
    endfunction

    function automatic int fraction_width(input int float_width);
        return float_width - 1 - exp_width(float_width);
    endfunction

    function automatic logic [63:0] nan_value(input int float_width);
        return (float_width == 32) ? 64'h0000_0000_FFC0_0000 : 64'hFFF8_0000_0000_0000;
    endfunction

    function automatic logic [63:0] inf_value(input int float_width);
        return (float_width == 32) ? 64'h0000_0000_7F80_0000 : 64'h7FF0_0000_0000_0000;
    endfunction

endpackage

// File: rtl/addfloat_req_fifo.sv
// Request FIFO: combinational head read, push/pop in the same cycle at any occupancy.
// No internal overflow protection: the producer must not push while full.
module addfloat_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/addfloat_issue_ctrl.sv
// Front end for the multi-cycle adder: queue requests, issue one at a time, buffer one result.
// Accept to out_valid is 9 edges when idle; a held result stalls completion in WAIT.
module addfloat_issue_ctrl
    import addfloat_pkg::*;
#(
    parameter int FLOAT_WIDTH = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_op1,
    input  logic [FLOAT_WIDTH-1:0] in_op2,
    input  logic                   in_sub,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   fa_start,
    output logic [FLOAT_WIDTH-1:0] fa_op1,
    output logic [FLOAT_WIDTH-1:0] fa_op2,
    output logic                   fa_op_sub,
    input  logic [FLOAT_WIDTH-1:0] fa_result,
    input  logic                   fa_nan,
    input  logic                   fa_ovf,
    input  logic                   fa_unf,
    input  logic                   fa_zero,
    input  logic                   fa_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out_result,
    output logic [3:0]             out_flags,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   busy
);

    typedef struct packed {
        logic [FLOAT_WIDTH-1:0] op1;
        logic [FLOAT_WIDTH-1:0] op2;
        logic                   sub;
        logic [TAG_WIDTH-1:0]   tag;
    } req_t;

    localparam int REQ_W = 2*FLOAT_WIDTH + 1 + TAG_WIDTH;

    issue_state_t                state, state_next;
    req_t                        in_req, head_req, op_reg;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        push, pop, capture, slot_free, guard_done;
    logic [1:0]                  guard_cnt;

    assign in_req    = '{op1: in_op1, op2: in_op2, sub: in_sub, tag: in_tag};
    assign in_ready  = !fifo_full;
    assign push      = in_valid && !fifo_full;
    assign slot_free = !out_valid || out_ready;
    assign guard_done = (guard_cnt == 2'(WAIT_GUARD_CYCLES));

    addfloat_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Operands only change on pop, which never happens between ISSUE and capture.
    assign fa_op1    = op_reg.op1;
    assign fa_op2    = op_reg.op2;
    assign fa_op_sub = op_reg.sub;

    assign busy = (fifo_count != '0) || (state != ST_IDLE) || out_valid;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        fa_start   = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fa_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (guard_done && fa_done && slot_free) begin
                    capture = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
            op_reg    <= '0;
        end else begin
            state <= state_next;
            if (state == ST_ISSUE) begin
                guard_cnt <= '0;
            end else if (state == ST_WAIT && !guard_done) begin
                guard_cnt <= guard_cnt + 1'b1;
            end
            if (pop) begin
                op_reg <= head_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_tag    <= '0;
        end else if (capture) begin
            out_valid            <= 1'b1;
            out_result           <= fa_result;
            out_flags[FLAG_NAN]  <= fa_nan;
            out_flags[FLAG_OVF]  <= fa_ovf;
            out_flags[FLAG_UNF]  <= fa_unf;
            out_flags[FLAG_ZERO] <= fa_zero;
            out_tag              <= op_reg.tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addfloat_issue_ctrl.sv
// Bench for addfloat_issue_ctrl: behavioural adder, scoreboard of expected results,
// directed scenarios for latency, throughput, backpressure and reset.
module tb_addfloat_issue_ctrl;

    localparam int FW    = 64;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_op1 = '0, in_op2 = '0;
    logic          in_sub = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          fa_start;
    logic [FW-1:0] fa_op1, fa_op2;
    logic          fa_op_sub;
    logic [FW-1:0] fa_result;
    logic          fa_nan, fa_ovf, fa_unf, fa_zero, fa_done;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [FW-1:0] out_result;
    logic [3:0]    out_flags;
    logic [TW-1:0] out_tag;
    logic          busy;

    addfloat_issue_ctrl #(.FLOAT_WIDTH(FW), .FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
        .in_sub(in_sub), .in_tag(in_tag),
        .fa_start(fa_start), .fa_op1(fa_op1), .fa_op2(fa_op2), .fa_op_sub(fa_op_sub),
        .fa_result(fa_result), .fa_nan(fa_nan), .fa_ovf(fa_ovf), .fa_unf(fa_unf),
        .fa_zero(fa_zero), .fa_done(fa_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // IEEE-754 double add/sub from real arithmetic; returns {flags, result}
    function automatic logic [67:0] model_add(input logic [63:0] a, input logic [63:0] b, input logic s);
        real ra, rb, r;
        logic [63:0] res;
        logic [3:0]  fl;
        if ((a[62:52] == 11'h7FF && a[51:0] != 0) || (b[62:52] == 11'h7FF && b[51:0] != 0))
            return {4'b1000, 64'hFFF8_0000_0000_0000};
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        r  = s ? (ra - rb) : (ra + rb);
        if (r == 0.0) return {4'b0001, 64'h0};
        res = $realtobits(r);
        fl  = 4'b0000;
        if (res[62:52] == 11'h7FF) fl[2] = 1'b1;
        if (res[62:52] == 11'h000) fl[1] = 1'b1;
        return {fl, res};
    endfunction

    // Adder: done drops one edge after start (stale for the first WAIT cycle),
    // rises 6 edges after start; operands are read at completion time.
    int          a_cnt;
    logic        a_done;
    logic [63:0] a_res;
    logic [3:0]  a_fl;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 0; a_done <= 1'b0; a_res <= '0; a_fl <= '0;
        end else if (fa_start) begin
            a_cnt <= 6;
        end else if (a_cnt > 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 6) a_done <= 1'b0;
            if (a_cnt == 1) begin
                a_done <= 1'b1;
                {a_fl, a_res} <= model_add(fa_op1, fa_op2, fa_op_sub);
            end
        end
    end
    assign fa_result = a_res;
    assign fa_nan    = a_fl[3];
    assign fa_ovf    = a_fl[2];
    assign fa_unf    = a_fl[1];
    assign fa_zero   = a_fl[0];
    assign fa_done   = a_done;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int          start_cnt = 0;
    logic        prev_start = 1'b0, prev_ov = 1'b0;
    int          rise_cycle = -1;
    int          hs_cycles[$];
    logic [63:0] last_res = '0;
    logic [3:0]  last_fl = '0, last_tag = '0;
    int          ready_low_accepts = -1;
    int          accepted = 0;
    int          acc_cycle = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
            prev_ov    = 1'b0;
        end else begin
            if (fa_start) begin
                start_cnt++;
                check("start_single_cycle", 64'(prev_start), 64'd0);
            end
            prev_start = fa_start;
            if (out_valid && !prev_ov) rise_cycle = cycle;
            prev_ov = out_valid;
            if (!in_ready && ready_low_accepts < 0) ready_low_accepts = accepted;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stale_out: result %h tag %h with no request outstanding", out_result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("out_result", out_result, e.res);
                    check("out_flags", 64'(out_flags), 64'(e.fl));
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                    last_res = out_result;
                    last_fl  = out_flags;
                    last_tag = out_tag;
                    hs_cycles.push_back(cycle);
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [3:0] t);
        int   n;
        logic rdy;
        logic ok;
        exp_t x;
        n = 0;
        ok = 1'b1;
        in_op1 = a; in_op2 = b; in_sub = s; in_tag = t; in_valid = 1'b1;
        forever begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                tests++; fails++; ok = 1'b0;
                $display("FAIL accept_timeout: tag %h not accepted in %0d cycles", t, n);
                break;
            end
        end
        if (ok) begin
            acc_cycle = cycle;
            accepted++;
            {x.fl, x.res} = model_add(a, b, s);
            x.tag = t;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_out_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(out_valid), 64'd1);
    endtask

    function automatic logic [63:0] d(input real r);
        return $realtobits(r);
    endfunction

    int base;
    int ov_seen;
    int n;

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fa_start", 64'(fa_start), 64'd0);
        check("rst_fa_op1", fa_op1, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_result", out_result, 64'd0);

        // Single add: 1.0 + 2.0
        base = start_cnt;
        send(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 4'd5);
        in_valid = 1'b0;
        wait_drain(40, "single_drain");
        check("single_latency", 64'(rise_cycle - acc_cycle), 64'd9);
        check("single_starts", 64'(start_cnt - base), 64'd1);
        check("single_result_lit", last_res, 64'h4008_0000_0000_0000);
        check("single_flags_lit", 64'(last_fl), 64'd0);
        check("single_tag_lit", 64'(last_tag), 64'd5);

        // Back-to-back stream of six
        repeat (3) @(posedge clk); #1;
        base = start_cnt;
        hs_cycles.delete();
        ready_low_accepts = -1;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            send(d(real'(i) + 1.0), d(0.5), 1'b0, 4'(i));
        end
        in_valid = 1'b0;
        wait_drain(120, "b2b_drain");
        check("b2b_full_point", 64'(ready_low_accepts), 64'(DEPTH + 1));
        check("b2b_starts", 64'(start_cnt - base), 64'd6);
        check("b2b_count", 64'(hs_cycles.size()), 64'd6);
        for (int i = 1; i < hs_cycles.size(); i++) begin
            check("b2b_spacing", 64'(hs_cycles[i] - hs_cycles[i-1]), 64'd8);
        end
        check("b2b_last_tag_lit", 64'(last_tag), 64'd5);

        // Subtract, and equal-operand subtract giving +0
        send(64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 4'd6);
        in_valid = 1'b0;
        wait_drain(40, "sub_drain");
        check("sub_result_lit", last_res, 64'h4000_0000_0000_0000);
        check("sub_flags_lit", 64'(last_fl), 64'd0);
        send(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 4'd7);
        in_valid = 1'b0;
        wait_drain(40, "zero_drain");
        check("zero_result_lit", last_res, 64'd0);
        check("zero_flags_lit", 64'(last_fl), 64'b0001);

        // NaN operand
        send(64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 4'd3);
        in_valid = 1'b0;
        wait_drain(40, "nan_drain");
        check("nan_result_lit", last_res, 64'hFFF8_0000_0000_0000);
        check("nan_flags_lit", 64'(last_fl), 64'b1000);

        // Backpressure: first result held, second op parked in WAIT
        out_ready = 1'b0;
        base = start_cnt;
        send(d(1.0), d(1.0), 1'b0, 4'd8);
        send(d(2.0), d(2.0), 1'b0, 4'd9);
        in_valid = 1'b0;
        wait_out_valid(40, "bp_first_valid");
        repeat (25) @(posedge clk); #1;
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_result", out_result, 64'h4000_0000_0000_0000);
        check("bp_hold_tag", 64'(out_tag), 64'd8);
        check("bp_op1_stable", fa_op1, 64'h4000_0000_0000_0000);
        check("bp_starts", 64'(start_cnt - base), 64'd2);
        check("bp_busy", 64'(busy), 64'd1);
        repeat (10) @(posedge clk); #1;
        check("bp_starts_later", 64'(start_cnt - base), 64'd2);
        check("bp_op2_stable", fa_op2, 64'h4000_0000_0000_0000);
        hs_cycles.delete();
        out_ready = 1'b1;
        wait_drain(10, "bp_drain");
        check("bp_hs_count", 64'(hs_cycles.size()), 64'd2);
        if (hs_cycles.size() == 2)
            check("bp_hs_consecutive", 64'(hs_cycles[1] - hs_cycles[0]), 64'd1);
        check("bp_last_tag_lit", 64'(last_tag), 64'd9);

        // Reset mid-operation with a result buffered
        out_ready = 1'b0;
        send(d(3.0), d(1.0), 1'b0, 4'd10);
        in_valid = 1'b0;
        wait_out_valid(40, "rm_first_valid");
        send(d(5.0), d(1.0), 1'b0, 4'd11);
        in_valid = 1'b0;
        n = 0;
        while (!fa_start && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rm_start_seen", 64'(fa_start), 64'd1);
        repeat (4) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", 64'(out_valid), 64'd0);
        check("rm_out_result", out_result, 64'd0);
        check("rm_out_tag", 64'(out_tag), 64'd0);
        check("rm_fa_op1", fa_op1, 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        ov_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check("rm_no_stale", 64'(ov_seen), 64'd0);
        send(d(1.5), d(1.5), 1'b0, 4'd12);
        in_valid = 1'b0;
        wait_drain(40, "rm_drain");
        check("rm_latency", 64'(rise_cycle - acc_cycle), 64'd9);
        check("rm_result_lit", last_res, 64'h4008_0000_0000_0000);
        check("rm_tag_lit", 64'(last_tag), 64'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
